// File: rtl/ram_port_arbiter.sv
// Three-requester round-robin arbiter in front of a single synchronous RAM port.
// Grants are registered; read data returns two cycles after the grant.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arb_en,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              ack,
  output logic [2:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  output logic                    busy
);

  logic [1:0] ptr;
  logic [2:0] eligible;
  logic [2:0] rd_pend;
  logic [1:0] ord0, ord1, ord2;
  logic       grant_valid;
  logic [1:0] grant_id;

  // A requester whose ack is currently showing is masked so it cannot win twice in a row.
  assign eligible = req & ~ack & {3{arb_en}};

  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (ptr)
      2'd1: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd2: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: ;
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    if (eligible[ord0]) begin
      grant_valid = 1'b1;
      grant_id    = ord0;
    end else if (eligible[ord1]) begin
      grant_valid = 1'b1;
      grant_id    = ord1;
    end else if (eligible[ord2]) begin
      grant_valid = 1'b1;
      grant_id    = ord2;
    end
  end

  // rd_pend tracks a read whose address is on the RAM port this cycle; its data lands next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 2'd0;
      ack      <= 3'b000;
      rd_pend  <= 3'b000;
      rvalid   <= 3'b000;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ack     <= 3'b000;
      rd_pend <= 3'b000;
      ram_we  <= 1'b0;
      rvalid  <= rd_pend;
      if (grant_valid) begin
        ack      <= 3'b001 << grant_id;
        ram_we   <= we[grant_id];
        ram_addr <= addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din  <= wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        ptr      <= (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
        if (!we[grant_id]) begin
          rd_pend <= 3'b001 << grant_id;
        end
      end
    end
  end

  assign rdata = (|rvalid) ? ram_dout : '0;
  assign busy  = (|ack) | (|rd_pend);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arb_en;
  logic [2:0]    req;
  logic [2:0]    we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    ack;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:65535];

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, contents preloaded while reset is held
  always @(posedge clk) begin
    if (rst) begin
      mem[16'h1234] <= 8'hA5;
      mem[16'h0100] <= 8'h11;
      mem[16'h0101] <= 8'h22;
      mem[16'h0102] <= 8'h33;
      ram_dout      <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] r, input logic [2:0] w);
    arb_en = en;
    req    = r;
    we     = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  ack_exp [6];
    logic [7:0]  rd_exp  [6];
    logic [15:0] addr_exp[6];
    ack_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rd_exp   = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    addr_exp = '{16'h0100, 16'h0101, 16'h0102, 16'h0100, 16'h0101, 16'h0102};

    rst   = 1'b1;
    addr  = '0;
    wdata = '0;
    applyStimulus(1'b0, 3'b000, 3'b000);
    tick();
    tick();
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("rst_ram_din", 32'(ram_din), 32'h0);
    checkOutput("rst_rdata", 32'(rdata), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single read by requester 1
    addr[1*AW +: AW] = 16'h1234;
    applyStimulus(1'b1, 3'b010, 3'b000);
    tick();
    checkOutput("rd_ack", 32'(ack), 32'h2);
    checkOutput("rd_ram_addr", 32'(ram_addr), 32'h1234);
    checkOutput("rd_ram_we", 32'(ram_we), 32'h0);
    checkOutput("rd_busy", 32'(busy), 32'h1);
    checkOutput("rd_rvalid_early", 32'(rvalid), 32'h0);
    applyStimulus(1'b1, 3'b000, 3'b000);
    tick();
    checkOutput("rd_rvalid", 32'(rvalid), 32'h2);
    checkOutput("rd_rdata", 32'(rdata), 32'hA5);
    checkOutput("rd_ack_clear", 32'(ack), 32'h0);
    tick();
    checkOutput("rd_rvalid_clear", 32'(rvalid), 32'h0);
    checkOutput("rd_busy_clear", 32'(busy), 32'h0);

    // Contention from reset: all three read continuously
    rst = 1'b1;
    addr[0*AW +: AW] = 16'h0100;
    addr[1*AW +: AW] = 16'h0101;
    addr[2*AW +: AW] = 16'h0102;
    applyStimulus(1'b1, 3'b111, 3'b000);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("cont_ack%0d", i), 32'(ack), 32'(ack_exp[i]));
      checkOutput($sformatf("cont_addr%0d", i), 32'(ram_addr), 32'(addr_exp[i]));
      if (i > 0) begin
        checkOutput($sformatf("cont_rvalid%0d", i), 32'(rvalid), 32'(ack_exp[i-1]));
        checkOutput($sformatf("cont_rdata%0d", i), 32'(rdata), 32'(rd_exp[i-1]));
      end
    end
    applyStimulus(1'b1, 3'b000, 3'b000);
    tick();
    checkOutput("cont_last_rvalid", 32'(rvalid), 32'h4);
    checkOutput("cont_last_rdata", 32'(rdata), 32'h33);
    checkOutput("cont_no_extra_ack", 32'(ack), 32'h0);
    tick();

    // Write by requester 0, then read back by requester 2
    addr[0*AW +: AW]  = 16'h0010;
    wdata[0*DW +: DW] = 8'h3C;
    applyStimulus(1'b1, 3'b001, 3'b001);
    tick();
    checkOutput("wr_ack", 32'(ack), 32'h1);
    checkOutput("wr_ram_we", 32'(ram_we), 32'h1);
    checkOutput("wr_ram_addr", 32'(ram_addr), 32'h0010);
    checkOutput("wr_ram_din", 32'(ram_din), 32'h3C);
    addr[2*AW +: AW] = 16'h0010;
    applyStimulus(1'b1, 3'b100, 3'b000);
    tick();
    checkOutput("wr_rd_ack", 32'(ack), 32'h4);
    checkOutput("wr_rd_ram_we", 32'(ram_we), 32'h0);
    checkOutput("wr_no_rvalid", 32'(rvalid), 32'h0);
    applyStimulus(1'b1, 3'b000, 3'b000);
    tick();
    checkOutput("wr_rd_rvalid", 32'(rvalid), 32'h4);
    checkOutput("wr_rd_rdata", 32'(rdata), 32'h3C);
    tick();

    // arb_en gate, then in-flight read completes after arb_en drops again
    addr[0*AW +: AW] = 16'h1234;
    applyStimulus(1'b0, 3'b001, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("gate_ack%0d", i), 32'(ack), 32'h0);
      checkOutput($sformatf("gate_we%0d", i), 32'(ram_we), 32'h0);
    end
    applyStimulus(1'b1, 3'b001, 3'b000);
    tick();
    checkOutput("gate_ack_open", 32'(ack), 32'h1);
    applyStimulus(1'b0, 3'b000, 3'b000);
    tick();
    checkOutput("gate_rvalid", 32'(rvalid), 32'h1);
    checkOutput("gate_rdata", 32'(rdata), 32'hA5);
    tick();

    // Reset in the middle of a read by requester 1
    addr[1*AW +: AW] = 16'h0101;
    applyStimulus(1'b1, 3'b010, 3'b000);
    tick();
    checkOutput("mid_ack", 32'(ack), 32'h2);
    applyStimulus(1'b1, 3'b000, 3'b000);
    #4;
    rst = 1'b1;
    tick();
    checkOutput("mid_rvalid", 32'(rvalid), 32'h0);
    checkOutput("mid_busy", 32'(busy), 32'h0);
    addr[0*AW +: AW] = 16'h0100;
    applyStimulus(1'b1, 3'b011, 3'b000);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_ack0", 32'(ack), 32'h1);
    checkOutput("post_rst_rvalid", 32'(rvalid), 32'h0);
    applyStimulus(1'b1, 3'b010, 3'b000);
    tick();
    checkOutput("post_rst_ack1", 32'(ack), 32'h2);
    checkOutput("post_rst_rdata0", 32'(rdata), 32'h11);
    applyStimulus(1'b1, 3'b000, 3'b000);
    tick();
    checkOutput("post_rst_rvalid1", 32'(rvalid), 32'h2);
    checkOutput("post_rst_rdata1", 32'(rdata), 32'h22);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each RAM data word.
REQ-002 Parameter ADDR_WIDTH, default 16: width of each RAM address.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 arb_en  input  1  when high, new grants are allowed; when low, no new grants are issued and in-flight accesses complete.
REQ-006 req  input  3  per-requester access request; bit k belongs to requester k.
REQ-007 we  input  3  per-requester write flag; qualified by req.
REQ-008 addr  input  3*ADDR_WIDTH  per-requester address; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 wdata  input  3*DATA_WIDTH  per-requester write data; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 ack  output  3  one-cycle pulse: the request from requester k has been accepted.
REQ-011 rvalid  output  3  one-cycle pulse: rdata holds the read result for requester k.
REQ-012 rdata  output  DATA_WIDTH  shared read-return data, valid only while any rvalid bit is high.
REQ-013 ram_we  output  1  write enable to the RAM port.
REQ-014 ram_addr  output  ADDR_WIDTH  address to the RAM port.
REQ-015 ram_din  output  DATA_WIDTH  write data to the RAM port.
REQ-016 ram_dout  input  DATA_WIDTH  RAM port read data, valid one clock after the address is sampled.
REQ-017 busy  output  1  high while any access is in flight (ack or pending rvalid).

Function
REQ-018 In cycle N, the block SHALL select at most one winner among eligible requesters, where eligible means req[k]=1, arb_en=1, and ack[k]=0 in cycle N.
REQ-019 Selection SHALL be round-robin: the search starts at pointer p and proceeds p, p+1, p+2 mod 3, and the first eligible requester wins.
REQ-020 After a grant to requester k, p SHALL become (k+1) mod 3; p SHALL be unchanged when there is no grant.
REQ-021 For winner k in cycle N, the registered outputs in cycle N+1 SHALL be: ack[k]=1, ram_addr=addr_k, ram_din=wdata_k, and ram_we=we[k].
REQ-022 In any cycle without a grant, ram_we SHALL be 0; ram_addr and ram_din SHALL hold their previous values.
REQ-023 For a read granted in cycle N, in cycle N+2 the block SHALL drive rvalid[k]=1 and rdata=ram_dout; a write SHALL produce no rvalid.
REQ-024 Throughput: one grant per cycle to different requesters, with back-to-back reads pipelined; each requester SHALL receive at most one grant every two cycles (ack masking, REQ-018).
REQ-025 A requester SHALL hold req, we, addr and wdata stable until it sees ack, and SHALL present new or deasserted signals from the cycle after ack.
REQ-026 When arb_en goes low, the block SHALL issue no grant from that cycle on; an already-registered ack and a pending rvalid SHALL still complete.
REQ-027 busy SHALL equal (|ack) OR (read-pending stage valid).
REQ-028 A write followed by a read of the same address SHALL return the new data, because the RAM performs the writes in order.
REQ-029 At most one ack bit and at most one rvalid bit SHALL be high in any cycle.

Reset
REQ-030 While rst=1: ack=0, rvalid=0, ram_we=0, ram_addr=0, ram_din=0, rdata=0, busy=0, p=0, and the read-pending stage is cleared.
REQ-031 If rst asserts during an access, that access SHALL be dropped with no ack or rvalid after reset; the first grant after reset release SHALL start the search at requester 0.

Verification
REQ-032 Single read: req=3'b010, we=0, addr1=16'h1234, RAM holds 8'hA5 there -> ack=3'b010 at N+1, ram_addr=16'h1234 with ram_we=0 at N+1, rvalid=3'b010 with rdata=8'hA5 at N+2.
REQ-033 Contention: req=3'b111 held continuously from reset -> grant order 0,1,2,0,1,2, one ack per cycle, no requester granted on consecutive cycles.
REQ-034 Write then read: requester 0 writes 8'h3C to 16'h0010, then requester 2 reads 16'h0010 -> ram_we=1 on the write cycle, rvalid[2]=1 with rdata=8'h3C.
REQ-035 Gate: req=3'b001 with arb_en=0 for 5 cycles -> no ack and ram_we=0; arb_en rises -> ack[0] on the next cycle.
REQ-036 Reset mid-read: assert rst one cycle after ack[1] for a read -> rvalid stays 0 and busy=0; after release, req=3'b011 -> requester 0 is granted first.
